// File: rtl/lp_gearbox_pkg.sv
// Shared constants and helpers for the lp_gearbox width up-converter.
// Pure package: no logic, no latency.
// Helpers size residue/fill state and give the output pattern period.
package lp_gearbox_pkg;

   localparam int GB_NBITS_DEF = 12;
   localparam int GB_NIN_DEF   = 4;
   localparam int GB_NOUT_DEF  = 6;

   // Greatest common divisor (Euclid), elaboration-time use.
   function automatic int gb_gcd(int a, int b);
      int x;
      int y;
      int t;
      x = a;
      y = b;
      while (y != 0) begin
         t = x % y;
         x = y;
         y = t;
      end
      return x;
   endfunction

   // Least common multiple.
   function automatic int gb_lcm(int a, int b);
      return (a / gb_gcd(a, b)) * b;
   endfunction

   // Number of input words after which the strobe pattern repeats.
   function automatic int gb_period(int nin, int nout);
      return gb_lcm(nin, nout) / nin;
   endfunction

   // $clog2 that never yields a zero-width vector.
   function automatic int gb_clog2_min1(int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Width of fill/total arithmetic: must hold NOUT+NIN-1.
   function automatic int gb_fill_w(int nin, int nout);
      return gb_clog2_min1(nin + nout);
   endfunction

   // Residue store depth in samples (NOUT-1, at least one slot).
   function automatic int gb_store_n(int nout);
      return (nout > 1) ? (nout - 1) : 1;
   endfunction

endpackage

// File: rtl/lp_gearbox_shift.sv
// Sample-granular concatenate/shift: {dat_i, store_i[fill_i samples]} -> out word + new residue.
// Latency: purely combinational.
// No flow control; caller decides when the result is committed.
module lp_gearbox_shift
   import lp_gearbox_pkg::*;
#(
   parameter  int NBITS = GB_NBITS_DEF,
   parameter  int NIN   = GB_NIN_DEF,
   parameter  int NOUT  = GB_NOUT_DEF,
   localparam int SN    = gb_store_n(NOUT),
   localparam int FW    = gb_fill_w(NIN, NOUT),
   localparam int OW    = gb_clog2_min1(NOUT)
) (
   input  logic [SN*NBITS-1:0]   store_i,
   input  logic [FW-1:0]         fill_i,
   input  logic [NIN*NBITS-1:0]  dat_i,
   output logic [NOUT*NBITS-1:0] word_o,
   output logic [SN*NBITS-1:0]   store_o,
   output logic [OW-1:0]         fill_o,
   output logic                  emit_o
);

   // Padded so every residue read after an emit stays in range.
   localparam int CN = NOUT + NIN + SN;

   logic [NBITS-1:0] comb [CN];
   logic [FW-1:0]    total;

   // Build the combined sample stream: residue first (oldest), then new samples.
   always_comb begin
      for (int j = 0; j < CN; j++) begin
         comb[j] = '0;
      end
      for (int j = 0; j < SN; j++) begin
         if (FW'(j) < fill_i) begin
            comb[j] = store_i[j*NBITS +: NBITS];
         end
      end
      for (int k = 0; k < NIN; k++) begin
         comb[int'(fill_i) + k] = dat_i[k*NBITS +: NBITS];
      end
   end

   // Sample count after this word and whether a full output word is available.
   always_comb begin
      total  = fill_i + FW'(NIN);
      emit_o = (total >= FW'(NOUT));
   end

   // Oldest NOUT samples form the output word; leftovers shift down to sample 0.
   always_comb begin
      word_o  = '0;
      store_o = '0;
      for (int k = 0; k < NOUT; k++) begin
         word_o[k*NBITS +: NBITS] = comb[k];
      end
      for (int j = 0; j < SN; j++) begin
         store_o[j*NBITS +: NBITS] = emit_o ? comb[NOUT + j] : comb[j];
      end
      fill_o = emit_o ? OW'(total - FW'(NOUT)) : OW'(total);
   end

endmodule

// File: rtl/lp_gearbox_up.sv
// Sample-rate-preserving width up-converter NIN -> NOUT samples with frame realignment.
// Latency: one clock from the completing valid input word to ce_o/dat_o.
// No backpressure: every valid word is absorbed; output is a one-cycle strobe.
module lp_gearbox_up
   import lp_gearbox_pkg::*;
#(
   parameter  int NBITS = GB_NBITS_DEF,
   parameter  int NIN   = GB_NIN_DEF,
   parameter  int NOUT  = GB_NOUT_DEF,
   localparam int OW    = gb_clog2_min1(NOUT)
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic [NIN*NBITS-1:0]  dat_i,
   input  logic                  valid_i,
   input  logic                  clk_phase_i,
   output logic [NOUT*NBITS-1:0] dat_o,
   output logic                  ce_o,
   output logic                  sync_err_o,
   output logic [OW-1:0]         fill_o
);

   localparam int SN = gb_store_n(NOUT);
   localparam int FW = gb_fill_w(NIN, NOUT);

   if (NIN < 1 || NOUT < NIN) begin : g_param_err
      $error("lp_gearbox_up: illegal ratio NIN=%0d NOUT=%0d", NIN, NOUT);
   end

   logic [SN*NBITS-1:0]   store_r;
   logic [OW-1:0]         fill_r;
   logic [NOUT*NBITS-1:0] dat_r;
   logic                  ce_r;
   logic                  err_r;

   logic [FW-1:0]         eff_fill;
   logic [NOUT*NBITS-1:0] nxt_word;
   logic [SN*NBITS-1:0]   nxt_store;
   logic [OW-1:0]         nxt_fill;
   logic                  emit;

   // A frame marker discards whatever residue is held.
   always_comb begin
      eff_fill = clk_phase_i ? '0 : FW'(fill_r);
   end

   lp_gearbox_shift #(
      .NBITS (NBITS),
      .NIN   (NIN),
      .NOUT  (NOUT)
   ) u_shift (
      .store_i (store_r),
      .fill_i  (eff_fill),
      .dat_i   (dat_i),
      .word_o  (nxt_word),
      .store_o (nxt_store),
      .fill_o  (nxt_fill),
      .emit_o  (emit)
   );

   // Commit residue and output word on valid input; strobes are single-cycle.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         store_r <= '0;
         fill_r  <= '0;
         dat_r   <= '0;
         ce_r    <= 1'b0;
         err_r   <= 1'b0;
      end else begin
         ce_r  <= 1'b0;
         err_r <= 1'b0;
         if (valid_i) begin
            err_r   <= clk_phase_i && (fill_r != '0);
            store_r <= nxt_store;
            fill_r  <= nxt_fill;
            if (emit) begin
               dat_r <= nxt_word;
               ce_r  <= 1'b1;
            end
         end
      end
   end

   assign dat_o      = dat_r;
   assign ce_o       = ce_r;
   assign sync_err_o = err_r;
   assign fill_o     = fill_r;

endmodule

// File: tb/tb_lp_gearbox_up.sv
// Bench for lp_gearbox_up: three ratios (4->6, 8->8, 3->8) driven one at a time.
// A sample-queue reference model pushes expected output words onto a scoreboard.
// Outputs are checked 1 time unit after each active clock edge.
module tb_lp_gearbox_up;
   import lp_gearbox_pkg::*;

   localparam int NB = 12;

   logic         clk   = 1'b0;
   logic         rst_n = 1'b0;
   logic [127:0] din   = '0;
   logic         vld   = 1'b0;
   logic         ph    = 1'b0;
   int           cur   = 0;

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   logic [6*NB-1:0] dat_a;
   logic            ce_a, err_a;
   logic [2:0]      fill_a;
   logic [8*NB-1:0] dat_b;
   logic            ce_b, err_b;
   logic [2:0]      fill_b;
   logic [8*NB-1:0] dat_c;
   logic            ce_c, err_c;
   logic [2:0]      fill_c;

   lp_gearbox_up #(.NBITS(NB), .NIN(4), .NOUT(6)) u_dut_a (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .dat_i       (din[4*NB-1:0]),
      .valid_i     (vld && (cur == 0)),
      .clk_phase_i (ph),
      .dat_o       (dat_a),
      .ce_o        (ce_a),
      .sync_err_o  (err_a),
      .fill_o      (fill_a)
   );

   lp_gearbox_up #(.NBITS(NB), .NIN(8), .NOUT(8)) u_dut_b (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .dat_i       (din[8*NB-1:0]),
      .valid_i     (vld && (cur == 1)),
      .clk_phase_i (ph),
      .dat_o       (dat_b),
      .ce_o        (ce_b),
      .sync_err_o  (err_b),
      .fill_o      (fill_b)
   );

   lp_gearbox_up #(.NBITS(NB), .NIN(3), .NOUT(8)) u_dut_c (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .dat_i       (din[3*NB-1:0]),
      .valid_i     (vld && (cur == 2)),
      .clk_phase_i (ph),
      .dat_o       (dat_c),
      .ce_o        (ce_c),
      .sync_err_o  (err_c),
      .fill_o      (fill_c)
   );

   // Outputs of the instance currently under test, zero-extended.
   logic [127:0] o_dat, o_fill;
   logic         o_ce, o_err;
   always_comb begin
      o_dat  = '0;
      o_fill = '0;
      o_ce   = 1'b0;
      o_err  = 1'b0;
      case (cur)
         0: begin
            o_dat[6*NB-1:0] = dat_a;
            o_fill[2:0] = fill_a;
            o_ce = ce_a;
            o_err = err_a;
         end
         1: begin
            o_dat[8*NB-1:0] = dat_b;
            o_fill[2:0] = fill_b;
            o_ce = ce_b;
            o_err = err_b;
         end
         default: begin
            o_dat[8*NB-1:0] = dat_c;
            o_fill[2:0] = fill_c;
            o_ce = ce_c;
            o_err = err_c;
         end
      endcase
   end

   // Reference model state for the instance under test.
   int           nin  = 4;
   int           nout = 6;
   int           pend[$];
   logic [127:0] expq[$];
   logic [127:0] last_w = '0;

   task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Drive one cycle of stimulus, update the model, then check the registered result.
   task automatic step(input bit v, input bit p, input int base);
      bit           e_ce;
      bit           e_err;
      logic [127:0] w;
      e_ce  = 1'b0;
      e_err = v && p && (pend.size() != 0);
      din   = '0;
      for (int k = 0; k < nin; k++) begin
         din[k*NB +: NB] = NB'(base + k);
      end
      if (v) begin
         if (p) pend.delete();
         for (int k = 0; k < nin; k++) pend.push_back((base + k) & 'hFFF);
         if (pend.size() >= nout) begin
            w = '0;
            for (int k = 0; k < nout; k++) w[k*NB +: NB] = NB'(pend.pop_front());
            expq.push_back(w);
            last_w = w;
            e_ce = 1'b1;
         end
      end
      vld = v;
      ph  = p;
      @(posedge clk);
      #1;
      check_val("ce", 128'(o_ce), 128'(e_ce));
      check_val("sync_err", 128'(o_err), 128'(e_err));
      check_val("fill", o_fill, 128'(pend.size()));
      if (o_ce && expq.size() != 0) check_val("dat", o_dat, expq.pop_front());
      else if (!o_ce) check_val("dat_hold", o_dat, last_w);
      vld = 1'b0;
      ph  = 1'b0;
   endtask

   task automatic select(input int idx, input int ni, input int no);
      cur    = idx;
      nin    = ni;
      nout   = no;
      last_w = '0;
      pend.delete();
      check_val("scoreboard_empty", 128'(expq.size()), 128'(0));
      expq.delete();
   endtask

   initial begin
      select(0, 4, 6);
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_dat", o_dat, '0);
      check_val("rst_ce", 128'(o_ce), 128'(0));
      check_val("rst_err", 128'(o_err), 128'(0));
      check_val("rst_fill", o_fill, '0);
      rst_n = 1'b1;

      // 4->6 continuous, frame marker on word 0
      for (int w = 0; w < 6; w++) step(1'b1, w == 0, 4*w);
      // 4->6 with a gap after every word
      for (int w = 0; w < 6; w++) begin
         step(1'b1, 1'b0, 24 + 4*w);
         step(1'b0, 1'b0, 0);
      end
      // Marker arriving with 4 samples held: error pulse, residue discarded
      step(1'b1, 1'b0, 100);
      step(1'b1, 1'b1, 104);
      step(1'b1, 1'b0, 108);

      // Asynchronous reset between clock edges, right after a strobe
      #2;
      rst_n = 1'b0;
      #1;
      check_val("midrst_dat", o_dat, '0);
      check_val("midrst_ce", 128'(o_ce), 128'(0));
      check_val("midrst_fill", o_fill, '0);
      check_val("midrst_err", 128'(o_err), 128'(0));
      pend.delete();
      expq.delete();
      last_w = '0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step(1'b1, 1'b1, 200);
      step(1'b1, 1'b0, 204);
      step(1'b1, 1'b0, 208);

      // 8->8 passthrough with occasional gaps
      select(1, 8, 8);
      for (int i = 0; i < 9; i++) step((i % 3) != 2, i == 0, 300 + 8*i);

      // 3->8: one full pattern period, then a second one, then a misaligned marker
      select(2, 3, 8);
      for (int w = 0; w < gb_period(3, 8); w++) step(1'b1, w == 0, 3*w);
      for (int w = 0; w < gb_period(3, 8); w++) step(1'b1, w == 0, 600 + 3*w);
      step(1'b1, 1'b0, 700);
      step(1'b1, 1'b1, 703);
      for (int w = 0; w < 2; w++) step(1'b1, 1'b0, 706 + 3*w);

      check_val("drain", 128'(expq.size()), 128'(0));
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
